// File: rtl/skeleton_endpoint_finder.sv
// skeleton_endpoint_finder
// Consumes a raster-order skeleton bitstream, classifies every interior pixel
// from its 3x3 neighbourhood and queues the coordinates of endpoints in a
// small FIFO with a valid/ready head interface.
// Build option: define SKEL_BRANCH_DETECT_EN to also queue branch points
// (pt_type_out=1); without it the branch logic is absent and pt_type_out=0.
module skeleton_endpoint_finder #(
  parameter int HORIZONTAL_COUNT = 320,
  parameter int VERTICAL_COUNT   = 180,
  parameter int MAX_POINTS       = 16,
  localparam int HWIDTH = $clog2(HORIZONTAL_COUNT),
  localparam int VWIDTH = $clog2(VERTICAL_COUNT),
  localparam int CWIDTH = $clog2(MAX_POINTS + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [HWIDTH-1:0] hcount_in,
  input  logic [VWIDTH-1:0] vcount_in,
  input  logic              pixel_in,
  input  logic              pixel_valid_in,
  output logic [HWIDTH-1:0] pt_x_out,
  output logic [VWIDTH-1:0] pt_y_out,
  output logic              pt_type_out,
  output logic              pt_valid_out,
  input  logic              pt_ready_in,
  output logic              frame_done_out,
  output logic [CWIDTH-1:0] point_count_out,
  output logic              overflow_out
);

  localparam int                PWIDTH    = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
  localparam logic [CWIDTH-1:0] FULL      = CWIDTH'(MAX_POINTS);
  localparam logic [PWIDTH-1:0] LAST_SLOT = PWIDTH'(MAX_POINTS - 1);

  logic                        active;
  logic                        frame_start;
  logic                        take;
  logic [HORIZONTAL_COUNT-1:0] line1;
  logic [HORIZONTAL_COUNT-1:0] line2;
  logic [2:0]                  col_cur;
  logic [2:0]                  w_left;
  logic [2:0]                  w_mid;
  logic [2:0]                  w_right;
  logic                        eval_q;
  logic                        last_q;
  logic [HWIDTH-1:0]           cx_q;
  logic [VWIDTH-1:0]           cy_q;
  logic [7:0]                  ring;
  logic [3:0]                  nbr_count;
  logic                        is_end;
  logic                        is_branch;
  logic                        det_valid;

  logic [HWIDTH-1:0]           mem_x [MAX_POINTS];
  logic [VWIDTH-1:0]           mem_y [MAX_POINTS];
  logic [PWIDTH-1:0]           rd_ptr;
  logic [PWIDTH-1:0]           wr_ptr;
  logic [CWIDTH-1:0]           fill;
  logic                        full;
  logic                        push;
  logic                        pop;
  logic                        drop;

  function automatic logic [PWIDTH-1:0] bump(input logic [PWIDTH-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PWIDTH'(1);
  endfunction

  // Pixel (0,0) opens a frame; until then (e.g. after a mid-frame reset)
  // the stream is ignored.
  assign frame_start = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign take        = pixel_valid_in && (active || frame_start);

  // Column of the current pixel: bit2 = row v-2, bit1 = row v-1, bit0 = row v.
  assign col_cur = frame_start ? {2'b00, pixel_in}
                               : {line2[hcount_in], line1[hcount_in], pixel_in};

  // Frame-active flag, armed by the first frame start after reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active <= 1'b0;
    end else if (frame_start) begin
      active <= 1'b1;
    end
  end

  // Two previous-row line buffers, shifted one row per accepted pixel column.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      line1 <= '0;
      line2 <= '0;
    end else if (take) begin
      if (frame_start) begin
        line2 <= '0;
        line1 <= HORIZONTAL_COUNT'(pixel_in);
      end else begin
        line2[hcount_in] <= line1[hcount_in];
        line1[hcount_in] <= pixel_in;
      end
    end
  end

  // 3x3 window shift plus the one-cycle evaluate / last-pixel strobes.
  // Centres with h>=2, v>=2 are always interior, so borders never report.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      w_left         <= '0;
      w_mid          <= '0;
      w_right        <= '0;
      eval_q         <= 1'b0;
      last_q         <= 1'b0;
      cx_q           <= '0;
      cy_q           <= '0;
      frame_done_out <= 1'b0;
    end else begin
      eval_q         <= take && (hcount_in >= HWIDTH'(2)) && (vcount_in >= VWIDTH'(2));
      last_q         <= take && (hcount_in == HWIDTH'(HORIZONTAL_COUNT - 1))
                             && (vcount_in == VWIDTH'(VERTICAL_COUNT - 1));
      frame_done_out <= last_q;
      if (take) begin
        if (frame_start) begin
          w_left <= '0;
          w_mid  <= '0;
        end else begin
          w_left <= w_mid;
          w_mid  <= w_right;
        end
        w_right <= col_cur;
        cx_q    <= hcount_in - HWIDTH'(1);
        cy_q    <= vcount_in - VWIDTH'(1);
      end
    end
  end

  // Neighbour ring clockwise from top-left: TL,T,TR,R,BR,B,BL,L = bits 0..7.
  assign ring      = {w_left[1], w_left[0], w_mid[0], w_right[0],
                      w_right[1], w_right[2], w_mid[2], w_left[2]};
  assign nbr_count = 4'($countones(ring));
  assign is_end    = w_mid[1] && (nbr_count == 4'd1);
  assign det_valid = eval_q && (is_end || is_branch);

  assign full = (fill == FULL);
  assign pop  = pt_valid_out && pt_ready_in;
  // A push that lands on the frame-start edge is discarded with the flush.
  assign push = det_valid && !frame_start && (!full || pop);
  assign drop = det_valid && !frame_start && full && !pop;

`ifdef SKEL_BRANCH_DETECT_EN
  logic [7:0] ring_next;
  logic [3:0] rise_count;
  logic       mem_t [MAX_POINTS];

  // A 0->1 step between ring neighbours marks the start of one arm.
  assign ring_next  = {ring[0], ring[7:1]};
  assign rise_count = 4'($countones(~ring & ring_next));
  assign is_branch  = w_mid[1] && (rise_count >= 4'd3);

  // Point-type storage alongside the coordinate memory.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_t[wr_ptr] <= is_branch;
    end
  end

  assign pt_type_out = pt_valid_out && mem_t[rd_ptr];
`else
  assign is_branch   = 1'b0;
  assign pt_type_out = 1'b0;
`endif

  // Coordinate storage; contents are only visible through the gated head.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_x[wr_ptr] <= cx_q;
      mem_y[wr_ptr] <= cy_q;
    end
  end

  // FIFO pointers, occupancy, per-frame push count and sticky overflow.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fill            <= '0;
      point_count_out <= '0;
      overflow_out    <= 1'b0;
    end else if (frame_start) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fill            <= '0;
      point_count_out <= '0;
      overflow_out    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (push && !pop) begin
        fill <= fill + CWIDTH'(1);
      end else if (pop && !push) begin
        fill <= fill - CWIDTH'(1);
      end
      if (push && (point_count_out != FULL)) begin
        point_count_out <= point_count_out + CWIDTH'(1);
      end
      if (drop) begin
        overflow_out <= 1'b1;
      end
    end
  end

  assign pt_valid_out = (fill != '0);
  assign pt_x_out     = pt_valid_out ? mem_x[rd_ptr] : '0;
  assign pt_y_out     = pt_valid_out ? mem_y[rd_ptr] : '0;

endmodule

// File: tb/tb_skeleton_endpoint_finder.sv
// tb_skeleton_endpoint_finder
// Directed and randomized frames on an 8x6 image with a 4-deep point FIFO.
// Expected points come from a per-frame reference that applies the
// neighbour-count / ring-transition rules to a 2-D frame array.
module tb_skeleton_endpoint_finder;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int MP = 4;
`ifdef SKEL_BRANCH_DETECT_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] hc     = '0;
  logic [2:0] vc     = '0;
  logic       pix    = 1'b0;
  logic       pvalid = 1'b0;
  logic       ready  = 1'b1;
  logic [2:0] pt_x;
  logic [2:0] pt_y;
  logic       pt_type;
  logic       pt_valid;
  logic       frame_done;
  logic [2:0] count;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_count = 0;
  int done_ovf = 0;
  bit valid_seen = 1'b0;

  bit         frame [V][H];
  logic [6:0] exp_q [$];
  logic [6:0] got_q [$];

  skeleton_endpoint_finder #(
    .HORIZONTAL_COUNT(H),
    .VERTICAL_COUNT  (V),
    .MAX_POINTS      (MP)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .hcount_in      (hc),
    .vcount_in      (vc),
    .pixel_in       (pix),
    .pixel_valid_in (pvalid),
    .pt_x_out       (pt_x),
    .pt_y_out       (pt_y),
    .pt_type_out    (pt_type),
    .pt_valid_out   (pt_valid),
    .pt_ready_in    (ready),
    .frame_done_out (frame_done),
    .point_count_out(count),
    .overflow_out   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake and frame-done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (pt_valid) valid_seen = 1'b1;
    if (pt_valid && ready) got_q.push_back({pt_type, pt_x, pt_y});
    if (frame_done) begin
      done_cnt++;
      done_cyc   = cyc;
      done_count = int'(count);
      done_ovf   = int'(overflow);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, req);
    end
  endtask

  function automatic void clear_frame();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        frame[y][x] = 1'b0;
  endfunction

  // Reference: every interior set pixel with exactly one set neighbour is an
  // endpoint; with branch detection, >=3 rising steps around the ring is a
  // branch. Listed in raster order of the centre.
  function automatic void build_expected();
    int dx [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dy [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    exp_q.delete();
    for (int y = 1; y < V - 1; y++) begin
      for (int x = 1; x < H - 1; x++) begin
        int n;
        int rises;
        bit r [8];
        if (!frame[y][x]) continue;
        n = 0;
        rises = 0;
        for (int k = 0; k < 8; k++) begin
          r[k] = frame[y + dy[k]][x + dx[k]];
          n += int'(r[k]);
        end
        for (int k = 0; k < 8; k++)
          if (!r[k] && r[(k + 1) % 8]) rises++;
        if (n == 1) exp_q.push_back({1'b0, 3'(x), 3'(y)});
        else if (BRANCH_EN && rises >= 3) exp_q.push_back({1'b1, 3'(x), 3'(y)});
      end
    end
  endfunction

  // Sends raster pixels first..stop-1, with random idle gaps carrying junk.
  task automatic send_pixels(input bit gappy, input int first, input int stop);
    for (int k = first; k < stop; k++) begin
      if (gappy) begin
        while ($urandom_range(0, 3) == 0) begin
          pvalid = 1'b0;
          pix    = 1'($urandom_range(0, 1));
          hc     = 3'($urandom_range(0, 7));
          vc     = 3'($urandom_range(0, 7));
          @(negedge clk);
        end
      end
      pvalid = 1'b1;
      hc     = 3'(k % H);
      vc     = 3'(k / H);
      pix    = frame[k / H][k % H];
      @(negedge clk);
      last_acc = cyc;
    end
    pvalid = 1'b0;
    pix    = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 ready = v;
    @(negedge clk);
  endtask

  task automatic finish_frame(input string tag, input int n0);
    int i = 0;
    while (done_cnt == n0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    check({tag, " frame_done pulses"}, done_cnt - n0, 1);
    check({tag, " frame_done latency"}, done_cyc - last_acc, 1);
  endtask

  task automatic run_ready(input string tag);
    int n0;
    int kept;
    build_expected();
    got_q.delete();
    valid_seen = 1'b0;
    n0 = done_cnt;
    send_pixels(1'b1, 0, H * V);
    finish_frame(tag, n0);
    kept = (exp_q.size() > MP) ? MP : exp_q.size();
    check({tag, " point_count"}, done_count, kept);
    check({tag, " overflow"}, done_ovf, 0);
    check({tag, " valid ever"}, int'(valid_seen), int'(exp_q.size() > 0));
    check({tag, " points popped"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s point %0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
  endtask

  task automatic run_stalled(input string tag);
    int n0;
    int kept;
    set_ready(1'b0);
    build_expected();
    got_q.delete();
    n0 = done_cnt;
    send_pixels(1'b1, 0, H * V);
    finish_frame(tag, n0);
    kept = (exp_q.size() > MP) ? MP : exp_q.size();
    check({tag, " point_count"}, done_count, kept);
    check({tag, " overflow"}, done_ovf, int'(exp_q.size() > MP));
    check({tag, " valid while stalled"}, int'(pt_valid), int'(kept > 0));
    if (kept > 0) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("%s head hold %0d", tag, i), int'({pt_type, pt_x, pt_y}), int'(exp_q[0]));
        @(negedge clk);
      end
    end
    set_ready(1'b1);
    repeat (MP + 4) @(negedge clk);
    check({tag, " points drained"}, got_q.size(), kept);
    for (int i = 0; i < kept && i < got_q.size(); i++)
      check($sformatf("%s drained %0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    check({tag, " empty after drain"}, int'(pt_valid), 0);
  endtask

  initial begin
    int n0;

    // Reset state.
    #1;
    check("reset pt_valid", int'(pt_valid), 0);
    check("reset pt_x", int'(pt_x), 0);
    check("reset pt_y", int'(pt_y), 0);
    check("reset pt_type", int'(pt_type), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset point_count", int'(count), 0);
    check("reset overflow", int'(overflow), 0);
    #21 rst_n = 1'b1;
    @(negedge clk);

    // Horizontal line: endpoints at both ends.
    clear_frame();
    for (int x = 2; x <= 5; x++) frame[3][x] = 1'b1;
    run_ready("line");
    if (got_q.size() >= 2) begin
      check("line first point", int'(got_q[0]), int'({1'b0, 3'd2, 3'd3}));
      check("line second point", int'(got_q[1]), int'({1'b0, 3'd5, 3'd3}));
    end

    // Empty frame.
    clear_frame();
    run_ready("empty");

    // Six endpoints into a 4-deep FIFO with no pops: overflow.
    clear_frame();
    frame[1][1] = 1'b1; frame[1][2] = 1'b1;
    frame[3][4] = 1'b1; frame[3][5] = 1'b1;
    frame[4][1] = 1'b1; frame[4][2] = 1'b1;
    run_stalled("overflow");

    // Full top row plus one pixel below: nothing reportable.
    clear_frame();
    for (int x = 0; x < H; x++) frame[0][x] = 1'b1;
    frame[1][3] = 1'b1;
    run_ready("border");

    // Line frame with the consumer stalled for the whole frame.
    clear_frame();
    for (int x = 2; x <= 5; x++) frame[3][x] = 1'b1;
    run_stalled("stall");

    // Mid-frame reset, then the rest of that frame must be ignored.
    set_ready(1'b0);
    n0 = done_cnt;
    send_pixels(1'b1, 0, 4 * H + 6);
    repeat (2) @(negedge clk);
    check("midreset point pending", int'(pt_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset pt_valid", int'(pt_valid), 0);
    check("midreset pt_x", int'(pt_x), 0);
    check("midreset pt_y", int'(pt_y), 0);
    check("midreset point_count", int'(count), 0);
    check("midreset overflow", int'(overflow), 0);
    check("midreset frame_done", int'(frame_done), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    set_ready(1'b1);
    got_q.delete();
    send_pixels(1'b1, 4 * H + 6, H * V);
    repeat (6) @(negedge clk);
    check("after reset no frame_done", done_cnt - n0, 0);
    check("after reset no points", got_q.size(), 0);
    check("after reset point_count", int'(count), 0);
    run_ready("rerun");

    // T shape: branch at the junction only when branch detection is built.
    clear_frame();
    for (int x = 1; x <= 5; x++) frame[2][x] = 1'b1;
    frame[3][3] = 1'b1;
    frame[4][3] = 1'b1;
    run_ready("tee");

    // Random sparse frames, free-running consumer.
    for (int r = 0; r < 4; r++) begin
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          frame[y][x] = ($urandom_range(0, 3) == 0);
      run_ready($sformatf("rand%0d", r));
    end

    // Random denser frames, consumer stalled until frame end.
    for (int r = 0; r < 3; r++) begin
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          frame[y][x] = ($urandom_range(0, 2) == 0);
      run_stalled($sformatf("rstall%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
